// File: rtl/force_release_regfile.sv
// ------------------------------------------------------------------
// force_release_regfile: register file with WRITE/FORCE/RELEASE/READ
// command port and a one-entry read response buffer.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module force_release_regfile #(
  parameter int          WIDTH  = 32,
  parameter int          DEPTH  = 4,
  parameter logic [31:0] INIT   = 32'h666,
  localparam int         ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [WIDTH-1:0]  cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_forced,
  output logic [DEPTH-1:0]  forced_mask,
  output logic [15:0]       ign_cnt,
  output logic              addr_err
);

  localparam logic [1:0]        c_OP_WRITE   = 2'b00;
  localparam logic [1:0]        c_OP_FORCE   = 2'b01;
  localparam logic [1:0]        c_OP_RELEASE = 2'b10;
  localparam logic [1:0]        c_OP_READ    = 2'b11;
  localparam logic [WIDTH-1:0]  c_INIT       = WIDTH'(INIT);
  localparam logic [ADDR_W:0]   c_DEPTH      = (ADDR_W + 1)'(DEPTH);
  localparam logic [15:0]       c_IGN_MAX    = 16'hFFFF;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_val    [DEPTH];
  logic               r_forced [DEPTH];
  logic [WIDTH-1:0]   r_rsp_data;
  logic               r_rsp_forced;
  logic [15:0]        r_ign_cnt;
  logic               r_addr_err;

  logic               w_cmd_ready;
  logic               w_accept;
  logic               w_in_range;
  logic               w_do_wr;
  logic               w_do_frc;
  logic               w_do_rel;
  logic               w_rd_acc;
  logic               w_ign_inc;
  logic [DEPTH-1:0]   w_sel;
  logic [WIDTH-1:0]   w_tgt_val;
  logic               w_tgt_forced;
  logic [DEPTH-1:0]   w_forced_mask;

  // A stalled response blocks new commands; a consumed one frees the slot the same cycle.
  assign w_cmd_ready = (r_state == S_IDLE) | rsp_ready;
  assign w_accept    = cmd_valid & w_cmd_ready;
  assign w_in_range  = ({1'b0, cmd_addr} < c_DEPTH);
  assign w_do_wr     = (cmd_op == c_OP_WRITE);
  assign w_do_frc    = (cmd_op == c_OP_FORCE);
  assign w_do_rel    = (cmd_op == c_OP_RELEASE);
  assign w_rd_acc    = w_accept & w_in_range & (cmd_op == c_OP_READ);

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = w_accept & w_in_range & (cmd_addr == ADDR_W'(i));
    end
  end

  always_comb begin
    w_tgt_val    = '0;
    w_tgt_forced = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cmd_addr == ADDR_W'(i)) begin
        w_tgt_val    = r_val[i];
        w_tgt_forced = r_forced[i];
      end
    end
  end

  always_comb begin
    w_forced_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_forced_mask[i] = r_forced[i];
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // RELEASE only clears the flag, so the forced value survives until the next WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_val[gi]    <= c_INIT;
        r_forced[gi] <= 1'b0;
      end else if (w_sel[gi]) begin
        if (w_do_frc || (w_do_wr && !r_forced[gi])) begin
          r_val[gi] <= cmd_data;
        end
        if (w_do_frc) begin
          r_forced[gi] <= 1'b1;
        end else if (w_do_rel) begin
          r_forced[gi] <= 1'b0;
        end
      end
    end
  end

  assign w_ign_inc = w_accept & w_in_range & w_do_wr & w_tgt_forced & (r_ign_cnt != c_IGN_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ign_cnt <= '0;
    end else if (w_ign_inc) begin
      r_ign_cnt <= r_ign_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_err <= 1'b0;
    end else if (w_accept && !w_in_range) begin
      r_addr_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data   <= '0;
      r_rsp_forced <= 1'b0;
    end else if (w_rd_acc) begin
      r_rsp_data   <= w_tgt_val;
      r_rsp_forced <= w_tgt_forced;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_rd_acc) w_state_nxt = S_FULL;
      S_FULL: if (rsp_ready && !w_rd_acc) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready   = w_cmd_ready;
  assign rsp_valid   = (r_state == S_FULL);
  assign rsp_data    = r_rsp_data;
  assign rsp_forced  = r_rsp_forced;
  assign forced_mask = w_forced_mask;
  assign ign_cnt     = r_ign_cnt;
  assign addr_err    = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_force_release_regfile.sv
// ------------------------------------------------------------------
// tb_force_release_regfile: directed + randomized bench with a
// behavioural reference model.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_force_release_regfile;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_FRC = 2'b01;
  localparam logic [1:0] OP_REL = 2'b10;
  localparam logic [1:0] OP_RD  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_forced, addr_err;
  logic [1:0]  cmd_op, cmd_addr;
  logic [31:0] cmd_data, rsp_data;
  logic [3:0]  forced_mask;
  logic [15:0] ign_cnt;

  logic        v3, cr3, rv3, rr3, rf3, ae3;
  logic [1:0]  op3, a3;
  logic [31:0] d3, rd3;
  logic [2:0]  fm3;
  logic [15:0] ign3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  force_release_regfile #(.WIDTH(32), .DEPTH(4), .INIT(32'h666)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_forced(rsp_forced), .forced_mask(forced_mask),
    .ign_cnt(ign_cnt), .addr_err(addr_err)
  );

  force_release_regfile #(.WIDTH(32), .DEPTH(3), .INIT(32'h666)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(v3), .cmd_ready(cr3), .cmd_op(op3),
    .cmd_addr(a3), .cmd_data(d3),
    .rsp_valid(rv3), .rsp_ready(rr3), .rsp_data(rd3),
    .rsp_forced(rf3), .forced_mask(fm3),
    .ign_cnt(ign3), .addr_err(ae3)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: entry values/flags as arrays, response slot as a flag + data.
  logic [31:0] m_val [4];
  bit          m_frc [4];
  int          m_ign;
  bit          m_err;
  bit          m_rv;
  logic [31:0] m_rd;
  bit          m_rf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_val[i] = 32'h666;
        m_frc[i] = 1'b0;
      end
      m_ign = 0; m_err = 0; m_rv = 0; m_rd = '0; m_rf = 0;
    end else begin
      bit acc;
      acc = cmd_valid && (!m_rv || rsp_ready);
      if (m_rv && rsp_ready) m_rv = 0;
      if (acc) begin
        case (cmd_op)
          OP_WR: begin
            if (m_frc[cmd_addr]) m_ign = (m_ign < 65535) ? m_ign + 1 : 65535;
            else                 m_val[cmd_addr] = cmd_data;
          end
          OP_FRC: begin
            m_val[cmd_addr] = cmd_data;
            m_frc[cmd_addr] = 1'b1;
          end
          OP_REL: m_frc[cmd_addr] = 1'b0;
          default: begin
            m_rv = 1;
            m_rd = m_val[cmd_addr];
            m_rf = m_frc[cmd_addr];
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [3:0] mm;
      for (int i = 0; i < 4; i++) mm[i] = m_frc[i];
      chk("cmp_cmd_ready", {63'd0, cmd_ready}, {63'd0, (!m_rv || rsp_ready)});
      chk("cmp_rsp_valid", {63'd0, rsp_valid}, {63'd0, m_rv});
      if (m_rv) begin
        chk("cmp_rsp_data", {32'd0, rsp_data}, {32'd0, m_rd});
        chk("cmp_rsp_forced", {63'd0, rsp_forced}, {63'd0, m_rf});
      end
      chk("cmp_forced_mask", {60'd0, forced_mask}, {60'd0, mm});
      chk("cmp_ign_cnt", {48'd0, ign_cnt}, 64'(m_ign));
      chk("cmp_addr_err", {63'd0, addr_err}, {63'd0, m_err});
    end
  end

  task automatic issue(input logic [1:0] op, input logic [1:0] a, input logic [31:0] d);
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 50) begin
        chk("issue_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] d, input logic f);
    issue(OP_RD, a, 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, {63'd0, rsp_valid}, 64'd1);
    chk({nm, "_data"}, {32'd0, rsp_data}, {32'd0, d});
    chk({nm, "_forced"}, {63'd0, rsp_forced}, {63'd0, f});
    @(posedge clk); #1;
  endtask

  task automatic cmd3(input logic [1:0] op, input logic [1:0] a, input logic [31:0] d);
    v3 = 1'b1; op3 = op; a3 = a; d3 = d;
    @(posedge clk); #1;
    v3 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; rsp_ready = 1'b1;
    v3 = 1'b0; op3 = '0; a3 = '0; d3 = '0; rr3 = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;

    // reset / init
    @(negedge clk);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
    chk("rst_forced_mask", {60'd0, forced_mask}, 64'd0);
    chk("rst_ign_cnt", {48'd0, ign_cnt}, 64'd0);
    chk("rst_addr_err", {63'd0, addr_err}, 64'd0);
    @(posedge clk); #1;
    rd_chk("init_rd0", 2'd0, 32'h666, 1'b0);

    // out-of-range on a 3-entry instance
    chk("d3_err_init", {63'd0, ae3}, 64'd0);
    cmd3(OP_WR, 2'd3, 32'hABC);
    @(negedge clk);
    chk("d3_addr_err", {63'd0, ae3}, 64'd1);
    chk("d3_no_rsp", {63'd0, rv3}, 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      cmd3(OP_RD, 2'(i), 32'd0);
      @(negedge clk);
      chk("d3_rd_valid", {63'd0, rv3}, 64'd1);
      chk("d3_rd_data", {32'd0, rd3}, 64'h666);
      @(posedge clk); #1;
    end
    cmd3(OP_RD, 2'd3, 32'd0);
    @(negedge clk);
    chk("d3_rd3_no_rsp", {63'd0, rv3}, 64'd0);
    @(posedge clk); #1;
    cmd3(OP_WR, 2'd2, 32'h55);
    cmd3(OP_RD, 2'd2, 32'd0);
    @(negedge clk);
    chk("d3_rd2_data", {32'd0, rd3}, 64'h55);
    chk("d3_ign", {48'd0, ign3}, 64'd0);
    @(posedge clk); #1;

    // force / release on addr 1
    issue(OP_FRC, 2'd1, 32'hFFFF);
    chk("frc_mask", {60'd0, forced_mask}, 64'b0010);
    rd_chk("frc_rd", 2'd1, 32'hFFFF, 1'b1);
    issue(OP_WR, 2'd1, 32'h543);
    chk("ign_after_drop", {48'd0, ign_cnt}, 64'd1);
    rd_chk("drop_rd", 2'd1, 32'hFFFF, 1'b1);
    issue(OP_REL, 2'd1, 32'd0);
    chk("rel_mask", {60'd0, forced_mask}, 64'd0);
    rd_chk("rel_rd", 2'd1, 32'hFFFF, 1'b0);
    issue(OP_WR, 2'd1, 32'h544);
    rd_chk("wr_after_rel", 2'd1, 32'h544, 1'b0);
    chk("ign_stays", {48'd0, ign_cnt}, 64'd1);

    // backpressure
    issue(OP_WR, 2'd2, 32'hA5A5);
    rsp_ready = 1'b0;
    issue(OP_RD, 2'd1, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_rsp_data", {32'd0, rsp_data}, 64'h544);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_op = OP_RD; cmd_addr = 2'd2;
    @(negedge clk);
    chk("bp_ready_back", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", {63'd0, rsp_valid}, 64'd1);
    chk("b2b_data", {32'd0, rsp_data}, 64'hA5A5);
    @(posedge clk); #1;

    // same-entry hazard
    issue(OP_WR, 2'd2, 32'h12);
    rd_chk("hazard", 2'd2, 32'h12, 1'b0);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_addr  = 2'($urandom_range(0, 3));
      cmd_data  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;

    // reset mid-operation
    issue(OP_FRC, 2'd2, 32'hBEEF);
    rsp_ready = 1'b0;
    issue(OP_RD, 2'd2, 32'd0);
    @(negedge clk);
    chk("mid_valid_pre", {63'd0, rsp_valid}, 64'd1);
    chk("mid_frc2_pre", {63'd0, forced_mask[2]}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid_rst", {63'd0, rsp_valid}, 64'd0);
    chk("mid_mask_rst", {60'd0, forced_mask}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    rd_chk("mid_rd2", 2'd2, 32'h666, 1'b0);

    // ignore counter saturation
    issue(OP_FRC, 2'd3, 32'h7);
    cmd_valid = 1'b1; cmd_op = OP_WR; cmd_addr = 2'd3; cmd_data = 32'h99;
    repeat (65534) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("ign_fffe", {48'd0, ign_cnt}, 64'hFFFE);
    for (int k = 0; k < 3; k++) issue(OP_WR, 2'd3, 32'h98);
    chk("ign_sat", {48'd0, ign_cnt}, 64'hFFFF);
    rd_chk("sat_rd3", 2'd3, 32'h7, 1'b1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
